nibble_fifo: RTL and testbench
==============================

NIBBLE_FIFO -- requirements
Module: nibble_fifo

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits; SHALL be at least 1.
REQ-002 Parameter DEPTH, default 4, number of storage entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 flush  input  1  synchronous clear of FIFO contents.
REQ-006 in_valid  input  1  producer offers in_data this cycle.
REQ-007 in_data  input  WIDTH  write data.
REQ-008 in_ready  output  1  FIFO accepts a word this cycle.
REQ-009 out_valid  output  1  out_data holds the oldest stored word.
REQ-010 out_data  output  WIDTH  head-of-queue data, intended to feed the downstream register's d input.
REQ-011 out_ready  input  1  consumer takes out_data this cycle.
REQ-012 count  output  $clog2(DEPTH)+1  number of words currently stored.
REQ-013 ovf  output  1  sticky flag indicating a write was attempted while full.

Function
REQ-014 Push SHALL occur when in_valid=1 and in_ready=1 at a rising clk edge; in_data is written at wr_ptr and wr_ptr advances by 1.
REQ-015 Pop SHALL occur when out_valid=1 and out_ready=1 at a rising clk edge; rd_ptr advances by 1.
REQ-016 Both pointers SHALL wrap from DEPTH-1 to 0 with no skipped entry.
REQ-017 in_ready SHALL equal (count != DEPTH), decoded from registered state only; there is no combinational path from out_ready to in_ready.
REQ-018 out_valid SHALL equal (count != 0); out_data SHALL equal mem[rd_ptr] (first-word fall-through).
REQ-019 out_data SHALL be a don't-care while out_valid=0.
REQ-020 Write-to-read latency SHALL be 1 cycle: a word pushed into an empty FIFO at edge N is visible with out_valid=1 after edge N.
REQ-021 count update per edge: push only → +1; pop only → -1; push and pop together → unchanged.
REQ-022 Full with out_ready=1: pop only, no push (in_ready=0); count becomes DEPTH-1.
REQ-023 Empty: no pop possible; a simultaneous in_valid produces a push only.
REQ-024 Data SHALL leave in strict arrival order; no word is duplicated or lost except under flush or reset.
REQ-025 ovf SHALL set on an edge where in_valid=1 and in_ready=0; once set it stays 1 until reset.
REQ-026 flush=1 at an edge SHALL:
  - zero wr_ptr, rd_ptr and count;
  - take priority over any push or pop in the same cycle;
  - leave ovf unchanged.
REQ-027 Storage memory contents SHALL NOT be reset; validity derives only from count.

Reset
REQ-028 While reset_n=0, state SHALL clear asynchronously, independent of clk:
  - wr_ptr=0, rd_ptr=0, count=0, ovf=0;
  - outputs in_ready=1, out_valid=0.
REQ-029 Reset asserted mid-transfer SHALL discard all stored words; no pop is reported on that edge.
REQ-030 After reset_n rises, the first push SHALL be accepted at the first rising clk edge on which in_valid=1.

Verification
REQ-031 Reset mid-traffic: load 0x3 and 0x5, pulse reset_n low between edges → count=0, out_valid=0, in_ready=1 immediately, without waiting for a clk edge.
REQ-032 Fill and drain with out_ready=0: push 0x1, 0x2, 0x3, 0x4 → count=4, in_ready=0; then out_ready=1 for 4 cycles → out_data sequence 0x1, 0x2, 0x3, 0x4, ending with count=0.
REQ-033 Overflow: when full, hold in_valid=1 with in_data=0xF for 1 cycle → ovf=1, count stays 4, and 0xF never appears on out_data.
REQ-034 Simultaneous push and pop at count=2 (heads 0xA, 0xB; push 0xC) → count stays 2, next out_data=0xB; pointer wrap is exercised over 10 continuous transfers with no gaps or reordering.
REQ-035 Flush while full with in_valid=1 and out_ready=1 in the same cycle → count=0, out_valid=0, and ovf keeps its prior value.
REQ-036 Empty-FIFO latency: push 0x9 into an empty FIFO at edge N → out_valid=1 and out_data=0x9 after edge N, not before.

Source files
------------

// File: rtl/nibble_fifo_if.sv
// rtl/nibble_fifo_if.sv - handshake bundle between nibble_fifo and its producer/consumer
interface nibble_fifo_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    logic                     flush;
    logic                     in_valid;
    logic [WIDTH-1:0]         in_data;
    logic                     in_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     ovf;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, ovf
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, ovf
    );
endinterface

// File: rtl/nibble_fifo.sv
// rtl/nibble_fifo.sv - first-word fall-through FIFO with sticky overflow flag and synchronous flush
module nibble_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    nibble_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             ovf_q;
    logic             push;
    logic             pop;
    logic             ready;
    logic             valid;

    // Flow control decodes from the registered count only, so out_ready never reaches in_ready.
    assign ready = (cnt != FULL);
    assign valid = (cnt != '0);
    assign push  = bus.in_valid && ready;
    assign pop   = valid && bus.out_ready;

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.out_data  = mem[rd_ptr];
    assign bus.count     = cnt;
    assign bus.ovf       = ovf_q;

    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // A flush cycle neither sets nor clears the overflow record.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (!bus.flush && bus.in_valid && !ready) begin
            ovf_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_nibble_fifo.sv
// tb/tb_nibble_fifo.sv - self-checking bench for nibble_fifo using a vector table and a queue scoreboard
module tb_nibble_fifo;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    nibble_fifo_if #(.WIDTH(4), .DEPTH(4)) bus ();

    nibble_fifo #(.WIDTH(4), .DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic       fl;
        logic       iv;
        logic [3:0] d;
        logic       ordy;
        logic [2:0] exp_cnt;
    } vec_t;

    vec_t       tbl [12];
    logic [3:0] q [$];
    logic       m_ovf;
    int         checks;
    int         failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_state();
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() != 4));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("ovf", 32'(bus.ovf), 32'(m_ovf));
        if (q.size() != 0) begin
            chk("out_data", 32'(bus.out_data), 32'(q[0]));
        end
    endtask

    // Drives one cycle of stimulus, checks the pre-edge state, then advances the model for the coming edge.
    task automatic step(input logic fl, input logic iv, input logic [3:0] d, input logic ordy);
        int n;
        @(negedge clk);
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        check_state();
        n = q.size();
        if (fl) begin
            q.delete();
        end else begin
            if (ordy && n != 0) begin
                void'(q.pop_front());
            end
            if (iv && n != 4) begin
                q.push_back(d);
            end
            if (iv && n == 4) begin
                m_ovf = 1'b1;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_ovf    = 1'b0;
        reset_n  = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'h0;
        bus.out_ready = 1'b0;

        tbl[0]  = '{1'b0, 1'b1, 4'h1, 1'b0, 3'd1};
        tbl[1]  = '{1'b0, 1'b1, 4'h2, 1'b0, 3'd2};
        tbl[2]  = '{1'b0, 1'b1, 4'h3, 1'b0, 3'd3};
        tbl[3]  = '{1'b0, 1'b1, 4'h4, 1'b0, 3'd4};
        tbl[4]  = '{1'b0, 1'b1, 4'hF, 1'b0, 3'd4};
        tbl[5]  = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd3};
        tbl[6]  = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd2};
        tbl[7]  = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd1};
        tbl[8]  = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd0};
        tbl[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd0};
        tbl[10] = '{1'b0, 1'b1, 4'h9, 1'b1, 3'd1};
        tbl[11] = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd0};

        #2;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            @(posedge clk);
            #1;
            chk("tbl_count", 32'(bus.count), 32'(tbl[i].exp_cnt));
        end
        chk("ovf_after_full_write", 32'(bus.ovf), 32'd1);

        // Empty-FIFO latency: not visible before the edge, visible right after it.
        step(1'b0, 1'b1, 4'h9, 1'b0);
        chk("lat_pre_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_data", 32'(bus.out_data), 32'h9);
        step(1'b0, 1'b0, 4'h0, 1'b1);

        step(1'b0, 1'b1, 4'hA, 1'b0);
        step(1'b0, 1'b1, 4'hB, 1'b0);
        step(1'b0, 1'b1, 4'hC, 1'b1);
        @(posedge clk);
        #1;
        chk("pushpop_count", 32'(bus.count), 32'd2);
        chk("pushpop_head", 32'(bus.out_data), 32'hB);

        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 4'($urandom), 1'b1);
        end

        step(1'b0, 1'b1, 4'h5, 1'b0);
        step(1'b0, 1'b1, 4'h6, 1'b0);
        step(1'b1, 1'b1, 4'h7, 1'b1);
        @(posedge clk);
        #1;
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_ovf", 32'(bus.ovf), 32'd1);
        step(1'b0, 1'b0, 4'h0, 1'b0);

        // Reset mid-traffic, asserted and released between clock edges.
        step(1'b0, 1'b1, 4'h3, 1'b0);
        step(1'b0, 1'b1, 4'h5, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
        q.delete();
        m_ovf = 1'b0;
        #1;
        reset_n = 1'b1;

        step(1'b0, 1'b1, 4'h6, 1'b0);
        step(1'b0, 1'b1, 4'h8, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        @(negedge clk);
        #1;
        check_state();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
